// File: rtl/fdc_cmd_phase_if.sv
// Host-side data-register bus of the floppy controller: byte strobes, data,
// Main Status Register and interrupt line.
interface fdc_cmd_phase_if;
    logic       data_wr;
    logic       data_rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] msr;
    logic       irq;

    modport master (output data_wr, data_rd, din, input dout, msr, irq);
    modport slave  (input data_wr, data_rd, din, output dout, msr, irq);
endinterface

// File: rtl/fdc_cmd_phase.sv
// uPD765-style command/result phase engine: MSR, data-register handshake,
// command collection, result queue and controller interrupt.
module fdc_cmd_phase #(
    parameter int unsigned MAX_CMD    = 9,
    parameter int unsigned MAX_RES    = 7,
    parameter int unsigned NUM_DRIVES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_rst,
    fdc_cmd_phase_if.slave         host,
    output logic                   cmd_start,
    output logic [8*MAX_CMD-1:0]   cmd_bytes,
    output logic [3:0]             cmd_len,
    input  logic                   exec_nd,
    input  logic [NUM_DRIVES-1:0]  seek_busy,
    input  logic                   res_wr,
    input  logic [7:0]             res_data,
    input  logic                   res_done,
    input  logic                   int_req
);
    localparam int unsigned RW = $clog2(MAX_RES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_EXEC,
        ST_INVALID,
        ST_RESULT
    } state_t;

    state_t               state, state_n;
    logic [8*MAX_CMD-1:0] cmd_q, cmd_q_n;
    logic [3:0]           cmd_cnt, cmd_cnt_n;
    logic [3:0]           exp_len, exp_len_n;
    logic [3:0]           cmd_len_n;
    logic                 cmd_start_n;
    logic [7:0]           res_buf   [MAX_RES];
    logic [7:0]           res_buf_n [MAX_RES];
    logic [RW-1:0]        res_cnt, res_cnt_n;
    logic [RW-1:0]        rd_ptr, rd_ptr_n;
    logic                 irq_q, irq_n, irq_set, irq_clr;
    logic [7:0]           msr_q, msr_n;
    logic [7:0]           dout_q, dout_n;
    logic [3:0]           busy4;

    // Command length from the opcode's low five bits; 0 marks an invalid opcode.
    function automatic logic [3:0] decode_len(input logic [4:0] op);
        case (op)
            5'h02, 5'h05, 5'h06, 5'h09,
            5'h0C, 5'h11, 5'h19, 5'h1D: return 4'd9;
            5'h0D:                      return 4'd6;
            5'h03, 5'h0F:               return 4'd3;
            5'h04, 5'h07, 5'h0A:        return 4'd2;
            5'h08:                      return 4'd1;
            default:                    return 4'd0;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        cmd_q_n   = cmd_q;
        cmd_cnt_n = cmd_cnt;
        exp_len_n = exp_len;
        cmd_len_n = cmd_len;
        res_buf_n = res_buf;
        res_cnt_n = res_cnt;
        rd_ptr_n  = rd_ptr;
        irq_set   = int_req;
        irq_clr   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (host.data_wr) begin
                    irq_clr      = 1'b1;
                    cmd_q_n      = '0;
                    cmd_q_n[7:0] = host.din;
                    cmd_cnt_n    = 4'd1;
                    exp_len_n    = decode_len(host.din[4:0]);
                    if (exp_len_n == 4'd0)
                        state_n = ST_INVALID;
                    else if (exp_len_n == 4'd1)
                        state_n = ST_EXEC;
                    else
                        state_n = ST_CMD;
                end
            end
            ST_CMD: begin
                if (host.data_wr) begin
                    if (int'(cmd_cnt) < int'(MAX_CMD))
                        cmd_q_n[8*int'(cmd_cnt) +: 8] = host.din;
                    cmd_cnt_n = cmd_cnt + 4'd1;
                    if (cmd_cnt == exp_len - 4'd1)
                        state_n = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A byte pushed alongside res_done is counted before choosing the exit.
                if (res_wr && (res_cnt != RW'(MAX_RES))) begin
                    res_buf_n[res_cnt] = res_data;
                    res_cnt_n          = res_cnt + RW'(1);
                end
                if (res_done) begin
                    if (res_cnt_n == '0) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_RESULT;
                        irq_set = 1'b1;
                    end
                end
            end
            ST_INVALID: begin
                res_buf_n[0] = 8'h80;
                res_cnt_n    = RW'(1);
                rd_ptr_n     = '0;
                state_n      = ST_RESULT;
            end
            ST_RESULT: begin
                if (host.data_rd) begin
                    irq_clr = 1'b1;
                    if (rd_ptr + RW'(1) == res_cnt) begin
                        state_n   = ST_IDLE;
                        res_cnt_n = '0;
                        rd_ptr_n  = '0;
                    end else begin
                        rd_ptr_n = rd_ptr + RW'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        cmd_start_n = (state_n == ST_EXEC) && (state != ST_EXEC);
        if (cmd_start_n)
            cmd_len_n = exp_len_n;

        irq_n = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);

        busy4                   = '0;
        busy4[NUM_DRIVES-1:0]   = seek_busy;
        case (state_n)
            ST_IDLE:    msr_n = {4'b1000, busy4};
            ST_CMD:     msr_n = {4'b1001, busy4};
            ST_EXEC:    msr_n = {2'b00, exec_nd, 1'b1, busy4};
            ST_INVALID: msr_n = {4'b0001, busy4};
            ST_RESULT:  msr_n = {4'b1101, busy4};
            default:    msr_n = {4'b1000, busy4};
        endcase

        dout_n = (state_n == ST_RESULT) ? res_buf_n[rd_ptr_n] : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            cmd_cnt   <= '0;
            exp_len   <= '0;
            cmd_len   <= '0;
            cmd_start <= 1'b0;
            for (int unsigned i = 0; i < MAX_RES; i++)
                res_buf[i] <= '0;
            res_cnt   <= '0;
            rd_ptr    <= '0;
            irq_q     <= 1'b0;
            msr_q     <= 8'h80;
            dout_q    <= '0;
        end else if (sw_rst) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            cmd_cnt   <= '0;
            exp_len   <= '0;
            cmd_len   <= '0;
            cmd_start <= 1'b0;
            for (int unsigned i = 0; i < MAX_RES; i++)
                res_buf[i] <= '0;
            res_cnt   <= '0;
            rd_ptr    <= '0;
            irq_q     <= 1'b0;
            msr_q     <= 8'h80;
            dout_q    <= '0;
        end else begin
            state     <= state_n;
            cmd_q     <= cmd_q_n;
            cmd_cnt   <= cmd_cnt_n;
            exp_len   <= exp_len_n;
            cmd_len   <= cmd_len_n;
            cmd_start <= cmd_start_n;
            res_buf   <= res_buf_n;
            res_cnt   <= res_cnt_n;
            rd_ptr    <= rd_ptr_n;
            irq_q     <= irq_n;
            msr_q     <= msr_n;
            dout_q    <= dout_n;
        end
    end

    assign cmd_bytes = cmd_q;
    assign host.msr  = msr_q;
    assign host.dout = dout_q;
    assign host.irq  = irq_q;
endmodule

// File: tb/tb_fdc_cmd_phase.sv
// Directed bench for fdc_cmd_phase: command, result, invalid-opcode,
// interrupt-precedence and reset scenarios with hand-computed expectations.
module tb_fdc_cmd_phase;
    logic        clk = 1'b0;
    logic        rst;
    logic        sw_rst;
    logic        cmd_start;
    logic [71:0] cmd_bytes;
    logic [3:0]  cmd_len;
    logic        exec_nd;
    logic [3:0]  seek_busy;
    logic        res_wr;
    logic [7:0]  res_data;
    logic        res_done;
    logic        int_req;

    int n_vec = 0;
    int n_err = 0;

    fdc_cmd_phase_if bus ();

    fdc_cmd_phase #(
        .MAX_CMD    (9),
        .MAX_RES    (7),
        .NUM_DRIVES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_rst    (sw_rst),
        .host      (bus),
        .cmd_start (cmd_start),
        .cmd_bytes (cmd_bytes),
        .cmd_len   (cmd_len),
        .exec_nd   (exec_nd),
        .seek_busy (seek_busy),
        .res_wr    (res_wr),
        .res_data  (res_data),
        .res_done  (res_done),
        .int_req   (int_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic host_wr(input logic [7:0] b);
        bus.data_wr = 1'b1;
        bus.din     = b;
        tick();
        bus.data_wr = 1'b0;
        bus.din     = 8'h00;
    endtask

    task automatic host_rd();
        bus.data_rd = 1'b1;
        tick();
        bus.data_rd = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        res_wr   = 1'b1;
        res_data = b;
        tick();
        res_wr   = 1'b0;
        res_data = 8'h00;
    endtask

    task automatic finish_exec();
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
    endtask

    logic [7:0] rdat [7];

    initial begin
        rst = 1'b1; sw_rst = 1'b0;
        bus.data_wr = 1'b0; bus.data_rd = 1'b0; bus.din = 8'h00;
        exec_nd = 1'b0; seek_busy = 4'b0000;
        res_wr = 1'b0; res_data = 8'h00; res_done = 1'b0; int_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_msr", bus.msr, 8'h80);
        chk("rst_irq", bus.irq, 1'b0);
        chk("rst_dout", bus.dout, 8'h00);
        chk("rst_len", cmd_len, 4'd0);
        chk("rst_bytes", cmd_bytes, 72'h0);

        // Specify
        host_wr(8'h03);
        chk("spec_msr_cmd", bus.msr, 8'h90);
        host_wr(8'hDF);
        host_wr(8'h02);
        chk("spec_start", cmd_start, 1'b1);
        chk("spec_len", cmd_len, 4'd3);
        chk("spec_bytes", cmd_bytes, 72'h02DF03);
        tick();
        chk("spec_start_pulse", cmd_start, 1'b0);
        chk("spec_msr_exec", bus.msr, 8'h10);
        finish_exec();
        chk("spec_msr_done", bus.msr, 8'h80);
        chk("spec_irq", bus.irq, 1'b0);

        // Read Data with seven result bytes
        host_wr(8'h06); host_wr(8'h01); host_wr(8'h01); host_wr(8'h00);
        host_wr(8'h01); host_wr(8'h02); host_wr(8'h07); host_wr(8'h2A);
        host_wr(8'hFF);
        chk("rd_start", cmd_start, 1'b1);
        chk("rd_len", cmd_len, 4'd9);
        chk("rd_bytes", cmd_bytes, 72'hFF2A07020100010106);
        rdat = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02};
        for (int i = 0; i < 7; i++) push(rdat[i]);
        finish_exec();
        chk("rd_irq_set", bus.irq, 1'b1);
        chk("rd_msr_res", bus.msr, 8'hD0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("rd_dout%0d", i), bus.dout, rdat[i]);
            host_rd();
            if (i == 0) chk("rd_irq_clr", bus.irq, 1'b0);
        end
        chk("rd_msr_end", bus.msr, 8'h80);
        chk("rd_dout_end", bus.dout, 8'h00);

        // Invalid opcode
        host_wr(8'h1F);
        chk("inv_msr_busy", bus.msr, 8'h10);
        tick();
        chk("inv_msr_res", bus.msr, 8'hD0);
        chk("inv_irq", bus.irq, 1'b0);
        chk("inv_dout", bus.dout, 8'h80);
        host_rd();
        chk("inv_msr_end", bus.msr, 8'h80);

        // Seek with drive busy and EXM, then int_req in IDLE
        seek_busy = 4'b0010;
        exec_nd   = 1'b1;
        host_wr(8'h0F); host_wr(8'h01); host_wr(8'h28);
        chk("seek_msr_exec", bus.msr, 8'h32);
        finish_exec();
        chk("seek_msr_idle", bus.msr, 8'h82);
        seek_busy = 4'b0000;
        exec_nd   = 1'b0;
        tick();
        chk("seek_msr_clr", bus.msr, 8'h80);
        int_req = 1'b1; tick(); int_req = 1'b0;
        chk("int_irq_set", bus.irq, 1'b1);
        host_wr(8'h08);
        chk("int_irq_clr", bus.irq, 1'b0);
        chk("sense_start", cmd_start, 1'b1);
        chk("sense_len", cmd_len, 4'd1);
        finish_exec();

        // Result overflow: eighth byte dropped
        host_wr(8'h08);
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        finish_exec();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("ovf_dout%0d", i), bus.dout, 8'hA0 + 8'(i));
            host_rd();
        end
        chk("ovf_msr_end", bus.msr, 8'h80);

        // res_wr with res_done, then set-wins on the final read
        host_wr(8'h08);
        res_wr = 1'b1; res_data = 8'h5A; res_done = 1'b1;
        tick();
        res_wr = 1'b0; res_data = 8'h00; res_done = 1'b0;
        chk("same_msr", bus.msr, 8'hD0);
        chk("same_dout", bus.dout, 8'h5A);
        chk("same_irq", bus.irq, 1'b1);
        bus.data_rd = 1'b1; int_req = 1'b1;
        tick();
        bus.data_rd = 1'b0; int_req = 1'b0;
        chk("prec_msr", bus.msr, 8'h80);
        chk("prec_irq", bus.irq, 1'b1);
        host_wr(8'h08);
        chk("prec_irq_clr", bus.irq, 1'b0);
        finish_exec();

        // rst after four of nine Read Data bytes
        host_wr(8'h06); host_wr(8'h01); host_wr(8'h01); host_wr(8'h00);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("mid_rst_msr", bus.msr, 8'h80);
        chk("mid_rst_len", cmd_len, 4'd0);
        chk("mid_rst_bytes", cmd_bytes, 72'h0);
        host_wr(8'h08);
        chk("mid_new_start", cmd_start, 1'b1);
        chk("mid_new_len", cmd_len, 4'd1);
        chk("mid_new_bytes", cmd_bytes, 72'h08);
        push(8'h55); push(8'h66);
        finish_exec();
        chk("sw_dout0", bus.dout, 8'h55);
        host_rd();
        chk("sw_dout1", bus.dout, 8'h66);
        sw_rst = 1'b1; tick(); sw_rst = 1'b0;
        chk("sw_msr", bus.msr, 8'h80);
        chk("sw_dout", bus.dout, 8'h00);
        chk("sw_irq", bus.irq, 1'b0);
        host_wr(8'h08);
        chk("sw_new_start", cmd_start, 1'b1);
        chk("sw_new_msr", bus.msr, 8'h10);
        finish_exec();
        chk("sw_final_msr", bus.msr, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fdc_cmd_phase.md
Name: fdc_cmd_phase

Overview:
- Command/result phase engine for the uPD765-compatible floppy controller on the IRQ6/DRQ2 channel.
- Owns the Main Status Register and the data-register byte handshake.
- Collects command bytes and hands a complete command to the execution core.
- Queues result bytes for host readback and raises the controller interrupt.
- Parametrised successor to the fixed single-drive command path: drive count, command depth and result depth are configurable.

Parameters:
- MAX_CMD, 9, command buffer depth in bytes (must be ≥9).
- MAX_RES, 7, result buffer depth in bytes (must be ≥7).
- NUM_DRIVES, 4, number of drives with busy bits reported in the MSR (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sw_rst  in  1  synchronous soft reset from the DOR; same effect as rst.
- data_wr  in  1  one-cycle host write strobe to the data register (decoded from iow_n/aen/address).
- data_rd  in  1  one-cycle host read strobe of the data register.
- din  in  8  host write data.
- dout  out  8  result byte at the head of the result buffer; 0x00 outside RESULT.
- msr  out  8  Main Status Register.
- cmd_start  out  1  one-cycle pulse: command complete, execution begins.
- cmd_bytes  out  8*MAX_CMD  command bytes; byte0 = opcode in bits [7:0]; unused bytes zero.
- cmd_len  out  4  number of valid command bytes.
- exec_nd  in  1  core is in non-DMA execution; drives MSR bit 5.
- seek_busy  in  NUM_DRIVES  per-drive seek-in-progress flags.
- res_wr  in  1  core pushes res_data into the result buffer.
- res_data  in  8  result byte.
- res_done  in  1  core has finished execution.
- int_req  in  1  asynchronous-event interrupt request (seek/recal completion), one-cycle pulse.
- irq  out  1  controller interrupt, routed to irq6.

Behaviour:
- Reset (rst or sw_rst):
  - State IDLE.
  - msr = 0x80, irq = 0, cmd_start = 0, cmd_len = 0, cmd_bytes = 0, dout = 0x00.
  - Both buffers are empty and pointers cleared.
  - An rst asserted mid-command or mid-result discards all partial state.
- MSR format:
  - bit7 RQM, bit6 DIO, bit5 EXM (= exec_nd in EXEC, else 0), bit4 CB.
  - bits[NUM_DRIVES-1:0] = seek_busy; remaining low bits are 0.
- IDLE: RQM=1, DIO=0, CB=0.
  - data_wr latches din as byte0.
  - Expected length L is decoded from din[4:0]:
    - 0x02, 0x05, 0x06, 0x09, 0x0C, 0x11, 0x19, 0x1D → 9
    - 0x0D → 6
    - 0x03, 0x0F → 3
    - 0x04, 0x07, 0x0A → 2
    - 0x08 → 1
    - anything else → invalid.
  - If L=1 → EXEC next cycle. If L>1 → CMD. If invalid → INVALID.
  - data_wr in IDLE also clears irq.
- CMD: RQM=1, DIO=0, CB=1.
  - Each data_wr stores din at index count.
  - On the write of byte L-1, the next state is EXEC.
  - data_rd is ignored.
- EXEC: RQM=0, CB=1.
  - cmd_start pulses in the first EXEC cycle; cmd_len = L.
  - cmd_bytes and cmd_len stay stable until return to IDLE.
  - res_wr appends to the result buffer. Writes beyond MAX_RES are dropped.
  - data_wr and data_rd are ignored.
  - On res_done:
    - result count 0 → IDLE.
    - otherwise → RESULT and irq set in the same edge.
  - res_wr and res_done in the same cycle: the byte is stored first, then the transition is taken.
- INVALID: one cycle. Loads result buffer with a single byte 0x80, then → RESULT. irq is not set.
- RESULT: RQM=1, DIO=1, CB=1; dout = buffer[rd_ptr].
  - data_rd advances rd_ptr and clears irq.
  - On the read of the last byte, the next state is IDLE and the buffer is emptied.
  - data_wr is ignored.
- Interrupt precedence:
  - int_req sets irq in any state.
  - When a set and a clear occur in the same cycle, set wins.
- Latency: host strobe to state/MSR update is 1 clock (registered). dout and msr are registered from state.

Test Plan:
1. Reset then idle read: assert rst, release → msr=0x80, irq=0, dout=0x00.
2. Specify command: write 0x03, 0xDF, 0x02 → msr 0x90 after byte0.
   - cmd_start one pulse with cmd_len=3 and cmd_bytes[23:0]=0x02DF03.
   - res_done with no results → msr 0x80, irq 0.
3. Read Data command: write 0x06, 0x01, 0x01, 0x00, 0x01, 0x02, 0x07, 0x2A, 0xFF → cmd_start, cmd_len=9.
   - Core pushes 0x01, 0x00, 0x00, 0x01, 0x00, 0x01, 0x02 and res_done → irq=1, msr=0xD0.
   - Seven data_rd return those bytes in order; irq clears on the first read; msr=0x80 after the seventh.
4. Invalid opcode: write 0x1F → msr 0xD0, irq stays 0; data_rd returns 0x80; then msr=0x80.
5. Drive busy and EXM: during EXEC of Seek (0x0F, 0x01, 0x28) with seek_busy=4'b0010 and exec_nd=1 → msr=0x32.
   - int_req while IDLE → irq=1; the following data_wr of 0x08 clears irq and yields cmd_len=1.
6. Reset mid-operation: assert rst after 4 of 9 Read Data bytes → msr=0x80.
   - Next write 0x08 is treated as a new 1-byte command (cmd_start, cmd_len=1).
   - Repeat with sw_rst during RESULT → buffer emptied, dout=0x00.
